// File: rtl/opl2_pkg.sv
// Shared definitions for the OPL2 channel mixer: the output sample width and the mixer FSM state type.
// Contents: SAMPLE_WIDTH (signed width of the mixed DAC sample) and mix_state_t (IDLE/ACCUM/DONE).
// The mixer and the testbench both import this package.
package opl2_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mix_state_t;

endpackage : opl2_pkg

// File: rtl/saturate.sv
// Signed saturation of a wide value down to OUT_W bits. Purely combinational.
// Ports: i_dat (signed IN_W input), o_dat (signed OUT_W clamped result), o_clip (high when clamping occurred).
// IN_W must be larger than OUT_W.
module saturate #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_dat,
    output logic signed [OUT_W-1:0] o_dat,
    output logic                    o_clip
);

    // The value fits in OUT_W bits exactly when every bit from the output sign
    // position upward is a copy of the input sign bit.
    logic [IN_W-OUT_W:0] w_top;
    logic                w_ovf;

    assign w_top  = i_dat[IN_W-1:OUT_W-1];
    assign w_ovf  = ~((&w_top) | ~(|w_top));
    assign o_clip = w_ovf;

    always_comb begin
        o_dat = i_dat[OUT_W-1:0];
        if (w_ovf) begin
            o_dat = i_dat[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule : saturate

// File: rtl/opl2_channel_mixer.sv
// Sums NUM_CHANNELS signed operator contributions per sample period and publishes a saturated sample.
// Ports: clk/reset (sync, active high); sample_clk_en, op_valid/op_channel/op_out, channel_mute in;
//        channel_valid/channel/clip out (two edges after the final beat), underrun sticky out.
module opl2_channel_mixer
    import opl2_pkg::*;
#(
    parameter int NUM_CHANNELS = 9,
    parameter int OP_OUT_WIDTH = 13
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_clk_en,
    input  logic                           op_valid,
    input  logic [3:0]                     op_channel,
    input  logic signed [OP_OUT_WIDTH-1:0] op_out,
    input  logic [NUM_CHANNELS-1:0]        channel_mute,
    output logic                           channel_valid,
    output logic signed [SAMPLE_WIDTH-1:0] channel,
    output logic                           clip,
    output logic                           underrun
);

    // One guard bit on top of the log2 growth keeps the full-scale sum exact.
    localparam int ACC_W = OP_OUT_WIDTH + $clog2(NUM_CHANNELS) + 1;
    localparam int CNT_W = $clog2(NUM_CHANNELS + 1);
    localparam logic [CNT_W-1:0] CNT_N = CNT_W'(NUM_CHANNELS);

    mix_state_t r_state;
    mix_state_t w_state_nxt;

    logic signed [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_restart;
    logic                           r_underrun;
    logic                           r_stg_vld;
    logic signed [SAMPLE_WIDTH-1:0] r_stg_dat;
    logic                           r_stg_clip;
    logic                           r_out_vld;
    logic signed [SAMPLE_WIDTH-1:0] r_out_dat;
    logic                           r_out_clip;

    logic                           w_in_range;
    logic                           w_muted;
    logic signed [ACC_W-1:0]        w_contrib;
    logic [CNT_W-1:0]               w_cnt_nxt;
    logic                           w_start;
    logic                           w_beat;
    logic                           w_clear;
    logic                           w_publish;
    logic                           w_cut;
    logic signed [SAMPLE_WIDTH-1:0] w_sat_dat;
    logic                           w_sat_clip;

    // Out-of-range channel indices still count as beats but never contribute.
    always_comb begin
        w_in_range = 1'b0;
        w_muted    = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (op_channel == 4'(i)) begin
                w_in_range = 1'b1;
                w_muted    = channel_mute[i];
            end
        end
    end

    assign w_contrib = (op_valid && w_in_range && !w_muted)
                     ? {{(ACC_W-OP_OUT_WIDTH){op_out[OP_OUT_WIDTH-1]}}, op_out}
                     : '0;
    assign w_cnt_nxt = r_cnt + CNT_W'(op_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An early sample_clk_en in ACCUM goes through DONE so the partial sum is
    // published on the same path; r_restart then carries the swallowed
    // sample_clk_en into the next period. Any beat arriving with that early
    // sample_clk_en is dropped, since the new period starts from a cleared
    // accumulator. Because DONE is never entered twice in a row, publish
    // pulses are always at least two cycles apart.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat      = 1'b0;
        w_clear     = 1'b0;
        w_publish   = 1'b0;
        w_cut       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (sample_clk_en) begin
                    w_state_nxt = ACCUM;
                    w_start     = 1'b1;
                end
            end
            ACCUM: begin
                if (sample_clk_en) begin
                    w_state_nxt = DONE;
                    w_cut       = 1'b1;
                end else begin
                    w_beat = 1'b1;
                    if (w_cnt_nxt >= CNT_N) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_publish = 1'b1;
                if (sample_clk_en || r_restart) begin
                    w_state_nxt = ACCUM;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    saturate #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_WIDTH)
    ) u_saturate (
        .i_dat  (r_acc),
        .o_dat  (w_sat_dat),
        .o_clip (w_sat_clip)
    );

    // Publish path: DONE captures the saturated sum into a staging register,
    // which is transferred to the outputs one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_restart  <= 1'b0;
            r_underrun <= 1'b0;
            r_stg_vld  <= 1'b0;
            r_stg_dat  <= '0;
            r_stg_clip <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_clip <= 1'b0;
        end else begin
            if (w_start) begin
                r_acc <= w_contrib;
                r_cnt <= CNT_W'(op_valid);
            end else if (w_beat) begin
                r_acc <= r_acc + w_contrib;
                r_cnt <= w_cnt_nxt;
            end else if (w_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end

            if (w_cut) begin
                r_restart  <= 1'b1;
                r_underrun <= 1'b1;
            end else if (w_publish) begin
                r_restart <= 1'b0;
            end

            r_stg_vld <= w_publish;
            if (w_publish) begin
                r_stg_dat  <= w_sat_dat;
                r_stg_clip <= w_sat_clip;
            end

            r_out_vld  <= r_stg_vld;
            r_out_clip <= r_stg_vld & r_stg_clip;
            if (r_stg_vld) begin
                r_out_dat <= r_stg_dat;
            end
        end
    end

    assign channel_valid = r_out_vld;
    assign channel       = r_out_dat;
    assign clip          = r_out_clip;
    assign underrun      = r_underrun;

endmodule : opl2_channel_mixer

// File: tb/tb_opl2_channel_mixer.sv
// Directed testbench for opl2_channel_mixer with hand-computed expected samples.
// Inputs are driven on the falling edge; outputs are recorded on the falling edge.
// Prints one summary line and finishes on its own.
module tb_opl2_channel_mixer;
    import opl2_pkg::*;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           sample_clk_en;
    logic                           op_valid;
    logic [3:0]                     op_channel;
    logic signed [12:0]             op_out;
    logic [8:0]                     channel_mute;
    logic                           channel_valid;
    logic signed [SAMPLE_WIDTH-1:0] channel;
    logic                           clip;
    logic                           underrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int consec = 0;
    bit prev_vld = 1'b0;
    int pq_dat[$];
    bit pq_clip[$];
    int pq_cyc[$];

    opl2_channel_mixer #(
        .NUM_CHANNELS (9),
        .OP_OUT_WIDTH (13)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_clk_en (sample_clk_en),
        .op_valid      (op_valid),
        .op_channel    (op_channel),
        .op_out        (op_out),
        .channel_mute  (channel_mute),
        .channel_valid (channel_valid),
        .channel       (channel),
        .clip          (clip),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (channel_valid) begin
            pq_dat.push_back(int'(channel));
            pq_clip.push_back(clip);
            pq_cyc.push_back(cyc);
            if (prev_vld) consec++;
        end
        prev_vld = channel_valid;
    end

    task automatic drive(input bit sce, input bit vld, input logic [3:0] ch, input int val);
        @(negedge clk);
        sample_clk_en = sce;
        op_valid      = vld;
        op_channel    = ch;
        op_out        = val[12:0];
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 0);
    endtask

    task automatic send_beats(input int n, input bit first_sce, input int val, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < n; i++) begin
            drive(first_sce && (i == 0), 1'b1, 4'(i), val);
            last_cyc = cyc;
        end
    endtask

    task automatic wait_pulses(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (pq_dat.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sample_clk_en = 1'b0; op_valid = 1'b0;
        op_channel = 4'd0; op_out = '0; channel_mute = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (channel !== 16'sd0) begin bad++; $display("FAIL reset_channel got=%0d exp=0", channel); end
        total++; if (channel_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", channel_valid); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL reset_clip got=%b exp=0", clip); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    endtask

    task automatic test_basic();
        int lc; bit ok; int base;
        base = pq_dat.size();
        send_beats(9, 1'b1, 100, lc);
        idle();
        wait_pulses(base + 1, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL basic_timeout got=no_pulse exp=pulse");
        end else begin
            total++; if (pq_dat[base] !== 900) begin bad++; $display("FAIL basic_sum got=%0d exp=900", pq_dat[base]); end
            total++; if (pq_clip[base] !== 1'b0) begin bad++; $display("FAIL basic_clip got=%b exp=0", pq_clip[base]); end
            total++; if (pq_cyc[base] !== lc + 3) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", pq_cyc[base], lc + 3); end
        end
        repeat (3) @(negedge clk);
        total++; if (channel !== 16'sd900 || channel_valid !== 1'b0) begin
            bad++; $display("FAIL basic_hold got=%0d/%b exp=900/0", channel, channel_valid); end
    endtask

    task automatic test_saturation(input int val, input int exp_ch);
        int lc; bit ok; int base;
        base = pq_dat.size();
        send_beats(9, 1'b1, val, lc);
        idle();
        wait_pulses(base + 1, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL sat_timeout got=no_pulse exp=pulse");
        end else begin
            total++; if (pq_dat[base] !== exp_ch) begin bad++; $display("FAIL sat_value got=%0d exp=%0d", pq_dat[base], exp_ch); end
            total++; if (pq_clip[base] !== 1'b1) begin bad++; $display("FAIL sat_clip got=%b exp=1", pq_clip[base]); end
        end
    endtask

    task automatic test_mute();
        int lc; bit ok; int base;
        base = pq_dat.size();
        channel_mute = 9'h001;
        send_beats(9, 1'b1, 10, lc);
        idle();
        wait_pulses(base + 1, ok);
        channel_mute = '0;
        total++;
        if (!ok) begin bad++; $display("FAIL mute_timeout got=no_pulse exp=pulse"); end
        else if (pq_dat[base] !== 80) begin bad++; $display("FAIL mute_sum got=%0d exp=80", pq_dat[base]); end
    endtask

    task automatic test_underrun();
        int lc; bit ok; int base;
        base = pq_dat.size();
        send_beats(5, 1'b1, 7, lc);
        drive(1'b1, 1'b0, 4'd0, 0);
        idle();
        send_beats(9, 1'b0, 1, lc);
        idle();
        wait_pulses(base + 2, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL underrun_timeout got=%0d_pulses exp=2", pq_dat.size() - base);
        end else begin
            total++; if (pq_dat[base] !== 35) begin bad++; $display("FAIL underrun_partial got=%0d exp=35", pq_dat[base]); end
            total++; if (pq_dat[base + 1] !== 9) begin bad++; $display("FAIL underrun_next got=%0d exp=9", pq_dat[base + 1]); end
        end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_flag got=%b exp=1", underrun); end
    endtask

    task automatic test_bad_channel();
        int lc; bit ok; int base;
        base = pq_dat.size();
        drive(1'b1, 1'b1, 4'd12, 500);
        send_beats(8, 1'b0, 1, lc);
        idle();
        wait_pulses(base + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL badch_timeout got=no_pulse exp=pulse"); end
        else if (pq_dat[base] !== 8) begin bad++; $display("FAIL badch_sum got=%0d exp=8", pq_dat[base]); end
    endtask

    task automatic test_reset_mid();
        int lc; bit ok; int base;
        base = pq_dat.size();
        send_beats(4, 1'b1, 50, lc);
        @(negedge clk);
        reset = 1'b1; op_valid = 1'b0; sample_clk_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (pq_dat.size() !== base) begin bad++; $display("FAIL rstmid_pulse got=%0d exp=%0d", pq_dat.size(), base); end
        total++; if (channel !== 16'sd0) begin bad++; $display("FAIL rstmid_channel got=%0d exp=0", channel); end
        total++; if (channel_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", channel_valid); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL rstmid_clip got=%b exp=0", clip); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rstmid_underrun got=%b exp=0", underrun); end
        send_beats(9, 1'b1, 3, lc);
        idle();
        wait_pulses(base + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rstmid_timeout got=no_pulse exp=pulse"); end
        else if (pq_dat[base] !== 27) begin bad++; $display("FAIL rstmid_sum got=%0d exp=27", pq_dat[base]); end
    endtask

    task automatic test_back_to_back();
        int lc; bit ok; int base;
        base = pq_dat.size();
        send_beats(9, 1'b1, 2, lc);
        drive(1'b1, 1'b1, 4'd0, 1000);
        send_beats(9, 1'b0, 5, lc);
        idle();
        wait_pulses(base + 2, ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL b2b_timeout got=%0d_pulses exp=2", pq_dat.size() - base);
        end else begin
            total++; if (pq_dat[base] !== 18) begin bad++; $display("FAIL b2b_first got=%0d exp=18", pq_dat[base]); end
            total++; if (pq_dat[base + 1] !== 45) begin bad++; $display("FAIL b2b_second got=%0d exp=45", pq_dat[base + 1]); end
        end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun got=%b exp=0", underrun); end
        total++; if (consec !== 0) begin bad++; $display("FAIL valid_consecutive got=%0d exp=0", consec); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation(4095, 32767);
        test_saturation(-4096, -32768);
        test_mute();
        test_underrun();
        test_bad_channel();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_opl2_channel_mixer
